// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the multi-channel fan controller:
// FSM states, MAC term indices and accumulator sizing.
package fan_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_MAC0  = 4'd2,
    ST_MAC1  = 4'd3,
    ST_MAC2  = 4'd4,
    ST_MAC3  = 4'd5,
    ST_MAC4  = 4'd6,
    ST_WRITE = 4'd7,
    ST_DONE  = 4'd8
  } fan_state_e;

  localparam logic [2:0] TERM_B2   = 3'd0;
  localparam logic [2:0] TERM_B1   = 3'd1;
  localparam logic [2:0] TERM_B0   = 3'd2;
  localparam logic [2:0] TERM_A1   = 3'd3;
  localparam logic [2:0] TERM_A0   = 3'd4;
  localparam logic [2:0] TERM_NONE = 3'd7;

  localparam int ACC_GUARD_BITS = 3;

  function automatic int acc_width(input int reg_w, input int adc_w);
    return reg_w + adc_w + 1 + ACC_GUARD_BITS;
  endfunction

  function automatic logic [2:0] mac_term(input fan_state_e st);
    case (st)
      ST_MAC0: return TERM_B2;
      ST_MAC1: return TERM_B1;
      ST_MAC2: return TERM_B0;
      ST_MAC3: return TERM_A1;
      ST_MAC4: return TERM_A0;
      default: return TERM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Per-channel PWM generator; the duty is only taken over at counter wrap so
// an update mid-period can never produce a runt pulse.
module fan_pwm_gen #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clk_en_i,
  input  logic [W-1:0] period_i,
  input  logic [W-1:0] duty_i,
  output logic         pwm_o
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_s;
  logic [W-1:0] duty_act_r;
  logic [W-1:0] duty_act_s;
  logic         pwm_r;
  logic         pwm_s;

  // Next counter/duty; >= also recovers cleanly when the period shrinks
  always_comb begin
    cnt_s      = cnt_r;
    duty_act_s = duty_act_r;
    if (period_i == '0) begin
      cnt_s      = '0;
      duty_act_s = duty_act_r;
    end else if (cnt_r >= period_i - W'(1)) begin
      cnt_s      = '0;
      duty_act_s = duty_i;
    end else begin
      cnt_s      = cnt_r + W'(1);
      duty_act_s = duty_act_r;
    end
    pwm_s = (period_i != '0) && (cnt_s < duty_act_s);
  end

  // Counter, active duty and registered output
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_r      <= '0;
      duty_act_r <= '0;
      pwm_r      <= 1'b0;
    end else if (clk_en_i) begin
      cnt_r      <= cnt_s;
      duty_act_r <= duty_act_s;
      pwm_r      <= pwm_s;
    end
  end

  assign pwm_o = pwm_r;

endmodule

// File: rtl/fan_ctrl_mc.sv
// Multi-channel fan controller: one time-multiplexed IIR/PID datapath with a
// single multiplier serves all channels once per sample tick.
import fan_ctrl_pkg::*;

module fan_ctrl_mc #(
  parameter int NUM_CH        = 2,
  parameter int ADC_BITWIDTH  = 4,
  parameter int REG_BITWIDTH  = 8,
  parameter int FRAC_BITWIDTH = 6,
  parameter int TICK_DIV      = 200000
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           clk_en_i,
  input  logic [NUM_CH*ADC_BITWIDTH-1:0] adc_value_i,
  input  logic [NUM_CH*ADC_BITWIDTH-1:0] set_value_i,
  input  logic [NUM_CH-1:0]              ch_enable_i,
  input  logic [REG_BITWIDTH-1:0]        b2_i,
  input  logic [REG_BITWIDTH-1:0]        b1_i,
  input  logic [REG_BITWIDTH-1:0]        b0_i,
  input  logic [REG_BITWIDTH-1:0]        a1_i,
  input  logic [REG_BITWIDTH-1:0]        a0_i,
  input  logic [ADC_BITWIDTH:0]          pwm_period_i,
  input  logic [ADC_BITWIDTH-1:0]        pwm_min_i,
  output logic [NUM_CH-1:0]              pwm_o,
  output logic [NUM_CH*(ADC_BITWIDTH+1)-1:0] pid_val_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           overrun_o
);

  localparam int DW  = ADC_BITWIDTH + 1;
  localparam int PW  = REG_BITWIDTH + DW;
  localparam int AW  = acc_width(REG_BITWIDTH, ADC_BITWIDTH);
  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [AW-1:0] RND_HALF = AW'(2 ** (FRAC_BITWIDTH - 1));
  localparam logic signed [AW-1:0] Y_MAX_W  = AW'(2 ** ADC_BITWIDTH - 1);
  localparam logic signed [AW-1:0] Y_MIN_W  = AW'(-(2 ** ADC_BITWIDTH));

  fan_state_e state_r;
  fan_state_e state_s;
  logic       busy_r;
  logic       done_r;
  logic       overrun_r;
  logic       done_s;
  logic       overrun_s;
  logic       tick_s;
  logic       last_ch_s;
  logic       write_s;

  logic [CW-1:0]  tick_cnt_r;
  logic [CHW-1:0] ch_r;

  logic signed [DW-1:0] e_r;
  logic signed [DW-1:0] e_s;
  logic signed [AW-1:0] acc_r;
  logic signed [AW-1:0] acc_next_s;
  logic signed [AW-1:0] rnd_s;
  logic signed [DW-1:0] y_s;
  logic signed [DW-1:0] y_wr_s;

  logic signed [REG_BITWIDTH-1:0] coef_s;
  logic signed [DW-1:0]           data_s;
  logic                           sub_s;
  logic signed [PW-1:0]           product_s;

  logic [ADC_BITWIDTH-1:0] adc_arr_s [NUM_CH];
  logic [ADC_BITWIDTH-1:0] set_arr_s [NUM_CH];
  logic signed [DW-1:0]    x1_r  [NUM_CH];
  logic signed [DW-1:0]    x2_r  [NUM_CH];
  logic signed [DW-1:0]    y1_r  [NUM_CH];
  logic signed [DW-1:0]    y2_r  [NUM_CH];
  logic signed [DW-1:0]    pid_r [NUM_CH];

  assign tick_s    = clk_en_i && (tick_cnt_r == CW'(TICK_DIV - 1));
  assign last_ch_s = (ch_r == CHW'(NUM_CH - 1));
  assign write_s   = clk_en_i && (state_r == ST_WRITE);
  assign e_s       = $signed({1'b0, adc_arr_s[ch_r]}) - $signed({1'b0, set_arr_s[ch_r]});
  assign product_s = PW'(coef_s) * PW'(data_s);
  assign y_wr_s    = ch_enable_i[ch_r] ? y_s : '0;

  // Sample-period divider
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tick_cnt_r <= '0;
    end else if (clk_en_i) begin
      if (tick_cnt_r == CW'(TICK_DIV - 1)) tick_cnt_r <= '0;
      else                                 tick_cnt_r <= tick_cnt_r + CW'(1);
    end
  end

  // Next-state and status pulses; one state per enabled cycle
  always_comb begin
    state_s   = state_r;
    done_s    = 1'b0;
    overrun_s = tick_s && (state_r != ST_IDLE);
    if (clk_en_i) begin
      case (state_r)
        ST_IDLE:  state_s = tick_s ? ST_LOAD : ST_IDLE;
        ST_LOAD:  state_s = ST_MAC0;
        ST_MAC0:  state_s = ST_MAC1;
        ST_MAC1:  state_s = ST_MAC2;
        ST_MAC2:  state_s = ST_MAC3;
        ST_MAC3:  state_s = ST_MAC4;
        ST_MAC4:  state_s = ST_WRITE;
        ST_WRITE: state_s = last_ch_s ? ST_DONE : ST_LOAD;
        ST_DONE: begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end
        default:  state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state and registered status outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s != ST_IDLE);
      done_r    <= done_s;
      overrun_r <= overrun_s;
    end
  end

  // Operand select for the shared multiplier; feedback terms are subtracted
  always_comb begin
    coef_s = '0;
    data_s = '0;
    sub_s  = 1'b0;
    case (mac_term(state_r))
      TERM_B2: begin coef_s = b2_i; data_s = e_r;         end
      TERM_B1: begin coef_s = b1_i; data_s = x1_r[ch_r];  end
      TERM_B0: begin coef_s = b0_i; data_s = x2_r[ch_r];  end
      TERM_A1: begin coef_s = a1_i; data_s = y1_r[ch_r]; sub_s = 1'b1; end
      TERM_A0: begin coef_s = a0_i; data_s = y2_r[ch_r]; sub_s = 1'b1; end
      default: begin coef_s = '0;   data_s = '0;         sub_s = 1'b0; end
    endcase
    if (sub_s) acc_next_s = acc_r - AW'(product_s);
    else       acc_next_s = acc_r + AW'(product_s);
  end

  // Round half up, drop fraction bits, saturate to the output range
  always_comb begin
    rnd_s = (acc_r + RND_HALF) >>> FRAC_BITWIDTH;
    if (rnd_s > Y_MAX_W)      y_s = Y_MAX_W[DW-1:0];
    else if (rnd_s < Y_MIN_W) y_s = Y_MIN_W[DW-1:0];
    else                      y_s = rnd_s[DW-1:0];
  end

  // Datapath: error latch, accumulator, per-channel history and outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ch_r  <= '0;
      e_r   <= '0;
      acc_r <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        x1_r[i]  <= '0;
        x2_r[i]  <= '0;
        y1_r[i]  <= '0;
        y2_r[i]  <= '0;
        pid_r[i] <= '0;
      end
    end else if (clk_en_i) begin
      case (state_r)
        ST_IDLE: if (tick_s) ch_r <= '0;
        ST_LOAD: begin
          e_r   <= e_s;
          acc_r <= '0;
        end
        ST_MAC0, ST_MAC1, ST_MAC2, ST_MAC3, ST_MAC4: acc_r <= acc_next_s;
        ST_WRITE: begin
          if (ch_enable_i[ch_r]) begin
            x2_r[ch_r] <= x1_r[ch_r];
            x1_r[ch_r] <= e_r;
            y2_r[ch_r] <= y1_r[ch_r];
            y1_r[ch_r] <= y_s;
          end else begin
            x2_r[ch_r] <= '0;
            x1_r[ch_r] <= '0;
            y2_r[ch_r] <= '0;
            y1_r[ch_r] <= '0;
          end
          pid_r[ch_r] <= y_wr_s;
          if (!last_ch_s) ch_r <= ch_r + CHW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [DW-1:0] pid_next_s;
    logic [DW-1:0]        mag_s;
    logic [DW-1:0]        duty_s;

    assign adc_arr_s[c] = adc_value_i[c*ADC_BITWIDTH +: ADC_BITWIDTH];
    assign set_arr_s[c] = set_value_i[c*ADC_BITWIDTH +: ADC_BITWIDTH];
    assign pid_val_o[c*DW +: DW] = pid_r[c];

    // Duty target; bypasses the value being written so a same-cycle wrap sees it
    always_comb begin
      mag_s  = '0;
      duty_s = '0;
      if (write_s && (ch_r == CHW'(c))) pid_next_s = y_wr_s;
      else                              pid_next_s = pid_r[c];
      if (!ch_enable_i[c] || pid_next_s[DW-1] || (pid_next_s == '0)) begin
        duty_s = '0;
      end else begin
        mag_s = {1'b0, pid_next_s[ADC_BITWIDTH-1:0]};
        if (mag_s < {1'b0, pwm_min_i}) duty_s = {1'b0, pwm_min_i};
        else                           duty_s = mag_s;
        if (duty_s > pwm_period_i) duty_s = pwm_period_i;
        else                       duty_s = duty_s;
      end
    end

    fan_pwm_gen #(.W(DW)) u_pwm (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .clk_en_i (clk_en_i),
      .period_i (pwm_period_i),
      .duty_i   (duty_s),
      .pwm_o    (pwm_o[c])
    );
  end

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign overrun_o = overrun_r;

endmodule

// File: tb/tb_fan_ctrl_mc.sv
// Directed bench for fan_ctrl_mc: hand-computed vectors plus a small integer
// reference of the filter for the multi-tick PI run.
`timescale 1ns/1ps
module tb_fan_ctrl_mc;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rstn_ov;
  logic       clk_en;
  logic [7:0] adc_value;
  logic [7:0] set_value;
  logic [1:0] ch_enable;
  logic [7:0] b2, b1, b0, a1, a0;
  logic [4:0] pwm_period;
  logic [3:0] pwm_min;

  logic [1:0] pwm, pwm_ov;
  logic [9:0] pid_val, pid_ov;
  logic       busy, done, overrun;
  logic       busy_ov, done_ov, overrun_ov;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cb2, cb1, cb0, ca1, ca0;
  int mx1 [2], mx2 [2], my1 [2], my2 [2];

  always #5 clk = ~clk;

  fan_ctrl_mc #(.NUM_CH(2), .ADC_BITWIDTH(4), .REG_BITWIDTH(8),
                .FRAC_BITWIDTH(6), .TICK_DIV(40)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en),
    .adc_value_i(adc_value), .set_value_i(set_value), .ch_enable_i(ch_enable),
    .b2_i(b2), .b1_i(b1), .b0_i(b0), .a1_i(a1), .a0_i(a0),
    .pwm_period_i(pwm_period), .pwm_min_i(pwm_min),
    .pwm_o(pwm), .pid_val_o(pid_val), .busy_o(busy), .done_o(done), .overrun_o(overrun)
  );

  fan_ctrl_mc #(.NUM_CH(2), .ADC_BITWIDTH(4), .REG_BITWIDTH(8),
                .FRAC_BITWIDTH(6), .TICK_DIV(10)) dut_ov (
    .clk_i(clk), .rstn_i(rstn_ov), .clk_en_i(clk_en),
    .adc_value_i(adc_value), .set_value_i(set_value), .ch_enable_i(ch_enable),
    .b2_i(b2), .b1_i(b1), .b0_i(b0), .a1_i(a1), .a0_i(a0),
    .pwm_period_i(pwm_period), .pwm_min_i(pwm_min),
    .pwm_o(pwm_ov), .pid_val_o(pid_ov), .busy_o(busy_ov), .done_o(done_ov),
    .overrun_o(overrun_ov)
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pid_of(input int ch);
    logic [4:0] v;
    v = pid_val[ch*5 +: 5];
    return int'($signed(v));
  endfunction

  task automatic set_ch(input int ch, input int adc, input int set);
    adc_value[ch*4 +: 4] = 4'(adc);
    set_value[ch*4 +: 4] = 4'(set);
  endtask

  task automatic set_coef(input int vb2, input int vb1, input int vb0, input int va1, input int va0);
    cb2 = vb2; cb1 = vb1; cb0 = vb0; ca1 = va1; ca0 = va0;
    b2 = 8'(vb2); b1 = 8'(vb1); b0 = 8'(vb0); a1 = 8'(va1); a0 = 8'(va0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk_eq("done_seen", int'(seen), 1);
  endtask

  task automatic wait_busy(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk_eq("busy_seen", int'(seen), 1);
  endtask

  task automatic count_high(input int ch, output int n);
    n = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      n += int'(pwm[ch]);
    end
  endtask

  // Reference filter step, operating on plain integers
  function automatic int model_y(input int e, input int x1, input int x2, input int y1, input int y2);
    int acc, y;
    acc = cb2 * e + cb1 * x1 + cb0 * x2 - ca1 * y1 - ca0 * y2;
    y = (acc + 32) >>> 6;
    if (y > 15) y = 15;
    if (y < -16) y = -16;
    return y;
  endfunction

  task automatic model_tick(input int c, input int e);
    int y;
    y = model_y(e, mx1[c], mx2[c], my1[c], my2[c]);
    mx2[c] = mx1[c]; mx1[c] = e; my2[c] = my1[c]; my1[c] = y;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, e0, e1;
    int first_done, first_ov, last_done, n_done, n_ov;
    rstn = 1'b0; rstn_ov = 1'b0; clk_en = 1'b1;
    adc_value = 8'd0; set_value = 8'd0; ch_enable = 2'b11;
    pwm_period = 5'd18; pwm_min = 4'd3;
    set_coef(64, 0, 0, 0, 0);

    // Reset state
    do_reset();
    chk_eq("rst_pid", int'(pid_val), 0);
    chk_eq("rst_pwm", int'(pwm), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_overrun", int'(overrun), 0);

    // Unity gain, e=4 on ch0, e=0 on ch1
    set_ch(0, 9, 5); set_ch(1, 5, 5);
    wait_done(100);
    chk_eq("t1_pid0", pid_of(0), 4);
    chk_eq("t1_pid1", pid_of(1), 0);
    repeat (20) @(negedge clk);
    count_high(0, n); chk_eq("t1_duty0", n, 4);
    count_high(1, n); chk_eq("t1_duty1", n, 0);

    // Min clamp and negative output
    do_reset();
    set_ch(0, 6, 5); set_ch(1, 2, 9);
    wait_done(100);
    chk_eq("t2_pid0", pid_of(0), 1);
    chk_eq("t2_pid1", pid_of(1), -7);
    chk_eq("t2_pid1_raw", int'(pid_val[9:5]), 25);
    repeat (20) @(negedge clk);
    count_high(0, n); chk_eq("t2_duty0", n, 3);
    count_high(1, n); chk_eq("t2_duty1", n, 0);

    // Saturation at both rails
    do_reset();
    set_coef(127, 0, 0, 0, 0);
    set_ch(0, 15, 0); set_ch(1, 0, 15);
    wait_done(100);
    chk_eq("t3_sat_hi", pid_of(0), 15);
    chk_eq("t3_sat_lo", pid_of(1), -16);
    repeat (20) @(negedge clk);
    count_high(0, n); chk_eq("t3_duty0", n, 15);

    // Pure integrator: y += e each tick until saturation
    do_reset();
    set_coef(64, 0, 0, -64, 0);
    set_ch(0, 7, 5); set_ch(1, 2, 5);
    for (int k = 1; k <= 9; k++) begin
      wait_done(100);
      chk_eq($sformatf("t3_int0_%0d", k), pid_of(0), (2 * k > 15) ? 15 : 2 * k);
      chk_eq($sformatf("t3_int1_%0d", k), pid_of(1), (-3 * k < -16) ? -16 : -3 * k);
    end

    // Reference PI over 20 ticks, independent errors per channel
    do_reset();
    set_coef(94, 0, -93, 0, -64);
    e0 = 3; e1 = -5;
    set_ch(0, 10, 7); set_ch(1, 4, 9);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        set_ch(0, 5, 8); e0 = -3;
      end
      wait_done(100);
      model_tick(0, e0); model_tick(1, e1);
      chk_eq($sformatf("t4_pi0_%0d", k), pid_of(0), my1[0]);
      chk_eq($sformatf("t4_pi1_%0d", k), pid_of(1), my1[1]);
    end

    // Overrun: tick every 10 cycles, 15-cycle processing
    first_done = -1; first_ov = -1; last_done = -1; n_done = 0; n_ov = 0;
    rstn_ov = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn_ov = 1'b1;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(posedge clk); #1;
      if (done_ov) begin
        n_done++; last_done = cyc;
        if (first_done < 0) first_done = cyc;
      end
      if (overrun_ov) begin
        n_ov++;
        if (first_ov < 0) first_ov = cyc;
      end
    end
    chk_eq("t5_first_done", first_done, 25);
    chk_eq("t5_first_ovr", first_ov, 20);
    chk_eq("t5_last_done", last_done, 65);
    chk_eq("t5_n_done", n_done, 3);
    chk_eq("t5_n_ovr", n_ov, 3);

    // Reset in MAC2 after history has built up
    do_reset();
    set_coef(94, 0, -93, 0, -64);
    set_ch(0, 10, 7); set_ch(1, 4, 9);
    for (int k = 0; k < 3; k++) wait_done(100);
    wait_busy(100);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk_eq("t6_rst_pid", int'(pid_val), 0);
    chk_eq("t6_rst_busy", int'(busy), 0);
    chk_eq("t6_rst_pwm", int'(pwm), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
    end
    wait_done(100);
    model_tick(0, 3); model_tick(1, -5);
    chk_eq("t6_clean0", pid_of(0), my1[0]);
    chk_eq("t6_clean1", pid_of(1), my1[1]);
    chk_eq("t6_clean1_hand", pid_of(1), -7);

    // Disabling ch1 clears its output and PWM
    do_reset();
    set_coef(64, 0, 0, 0, 0);
    set_ch(0, 9, 5); set_ch(1, 9, 5);
    wait_done(100);
    chk_eq("t6_en_pid1", pid_of(1), 4);
    ch_enable = 2'b01;
    wait_done(100);
    chk_eq("t6_dis_pid1", pid_of(1), 0);
    chk_eq("t6_dis_pid0", pid_of(0), 4);
    repeat (20) @(negedge clk);
    count_high(1, n); chk_eq("t6_dis_duty1", n, 0);
    count_high(0, n); chk_eq("t6_dis_duty0", n, 4);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
